// File: rtl/tlb_pkg.sv
// TLB shared definitions: entry count default, field widths, entry layout.
// Used by the TLB and by cp0 when it builds entries for TLBWI/TLBWR.
package tlb_pkg;

  localparam int TLBNUM_DEF = 16;
  localparam int VPN2_W     = 19;
  localparam int ASID_W     = 8;
  localparam int PFN_W      = 20;
  localparam int C_W        = 3;
  // Probe result miss flag sits just above the index bits.
  localparam int PMISS_BIT  = $clog2(TLBNUM_DEF);

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    page_t             pg0;
    page_t             pg1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// One entry comparator: present, vpn2 equal, and global or asid equal.
// Ports: entry present/vpn2/asid/g, query vpn2/asid -> hit.
module tlb_match
  import tlb_pkg::*;
(
  input  logic              present,
  input  logic [VPN2_W-1:0] e_vpn2,
  input  logic [ASID_W-1:0] e_asid,
  input  logic              e_g,
  input  logic [VPN2_W-1:0] vpn2,
  input  logic [ASID_W-1:0] asid,
  output logic              hit
);

  assign hit = present
             && (e_vpn2 == vpn2)
             && (e_g || (e_asid == asid));

endmodule

// File: rtl/tlb.sv
// TLB: two registered search ports, registered probe, write, flush,
// combinational read port. Async active-low reset on control state only.
module tlb
  import tlb_pkg::*;
#(
  parameter int TLBNUM       = TLBNUM_DEF,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s0_valid,
  input  logic [VPN2_W-1:0]       s0_vpn2,
  input  logic                    s0_odd_page,
  input  logic [ASID_W-1:0]       s0_asid,
  output logic                    s0_done,
  output logic                    s0_found,
  output logic [TLBNUM_WIDTH-1:0] s0_index,
  output logic [PFN_W-1:0]        s0_pfn,
  output logic [C_W-1:0]          s0_c,
  output logic                    s0_d,
  output logic                    s0_v,
  input  logic                    s1_valid,
  input  logic [VPN2_W-1:0]       s1_vpn2,
  input  logic                    s1_odd_page,
  input  logic [ASID_W-1:0]       s1_asid,
  output logic                    s1_done,
  output logic                    s1_found,
  output logic [TLBNUM_WIDTH-1:0] s1_index,
  output logic [PFN_W-1:0]        s1_pfn,
  output logic [C_W-1:0]          s1_c,
  output logic                    s1_d,
  output logic                    s1_v,
  input  logic                    p_req,
  input  logic [VPN2_W-1:0]       p_vpn2,
  input  logic [ASID_W-1:0]       p_asid,
  output logic                    p_done,
  output logic [TLBNUM_WIDTH:0]   p_result,
  input  logic                    we,
  input  logic [TLBNUM_WIDTH-1:0] w_index,
  input  logic [VPN2_W-1:0]       w_vpn2,
  input  logic [ASID_W-1:0]       w_asid,
  input  logic                    w_g,
  input  logic [PFN_W-1:0]        w_pfn0,
  input  logic [C_W-1:0]          w_c0,
  input  logic                    w_d0,
  input  logic                    w_v0,
  input  logic [PFN_W-1:0]        w_pfn1,
  input  logic [C_W-1:0]          w_c1,
  input  logic                    w_d1,
  input  logic                    w_v1,
  input  logic [TLBNUM_WIDTH-1:0] r_index,
  output logic [VPN2_W-1:0]       r_vpn2,
  output logic [ASID_W-1:0]       r_asid,
  output logic                    r_g,
  output logic [PFN_W-1:0]        r_pfn0,
  output logic [C_W-1:0]          r_c0,
  output logic                    r_d0,
  output logic                    r_v0,
  output logic [PFN_W-1:0]        r_pfn1,
  output logic [C_W-1:0]          r_c1,
  output logic                    r_d1,
  output logic                    r_v1,
  input  logic                    flush
);

  localparam int NP = 3;

  logic [TLBNUM-1:0] present_q, present_d;
  tlb_entry_t        ent_q [TLBNUM];
  tlb_entry_t        ent_d [TLBNUM];

  always_comb begin
    present_d = present_q;
    ent_d     = ent_q;
    if (we) begin
      ent_d[w_index] = '{w_vpn2, w_asid, w_g,
                         '{w_pfn0, w_c0, w_d0, w_v0},
                         '{w_pfn1, w_c1, w_d1, w_v1}};
    end
    // Flush wins over a same-cycle write; payload still lands.
    if (flush) present_d = '0;
    else if (we) present_d[w_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  logic [VPN2_W-1:0] q_vpn2 [NP];
  logic [ASID_W-1:0] q_asid [NP];
  logic [TLBNUM-1:0] hit    [NP];

  assign q_vpn2[0] = s0_vpn2;
  assign q_vpn2[1] = s1_vpn2;
  assign q_vpn2[2] = p_vpn2;
  assign q_asid[0] = s0_asid;
  assign q_asid[1] = s1_asid;
  assign q_asid[2] = p_asid;

  for (genvar p = 0; p < NP; p++) begin : g_port
    for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
      tlb_match u_match (
        .present (present_q[i]),
        .e_vpn2  (ent_q[i].vpn2),
        .e_asid  (ent_q[i].asid),
        .e_g     (ent_q[i].g),
        .vpn2    (q_vpn2[p]),
        .asid    (q_asid[p]),
        .hit     (hit[p][i])
      );
    end
  end

  // {found, index}; lowest index wins, index is 0 on a miss.
  function automatic logic [TLBNUM_WIDTH:0] penc(
    input logic [TLBNUM-1:0] h
  );
    logic [TLBNUM_WIDTH:0] r;
    r = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (h[i]) r = {1'b1, i[TLBNUM_WIDTH-1:0]};
    end
    return r;
  endfunction

  logic [TLBNUM_WIDTH:0] enc [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) enc[p] = penc(hit[p]);
  end

  logic [1:0]              s_val, s_odd;
  logic [1:0]              s_done_q, s_done_d;
  logic [1:0]              s_found_q, s_found_d;
  logic [TLBNUM_WIDTH-1:0] s_idx_q [2];
  logic [TLBNUM_WIDTH-1:0] s_idx_d [2];
  page_t                   s_pg_q  [2];
  page_t                   s_pg_d  [2];
  logic                    p_done_q, p_done_d;
  logic [TLBNUM_WIDTH:0]   p_result_q, p_result_d;

  assign s_val = {s1_valid, s0_valid};
  assign s_odd = {s1_odd_page, s0_odd_page};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      s_done_d[p]  = s_val[p];
      s_found_d[p] = s_found_q[p];
      s_idx_d[p]   = s_idx_q[p];
      s_pg_d[p]    = s_pg_q[p];
      if (s_val[p]) begin
        s_found_d[p] = enc[p][TLBNUM_WIDTH];
        s_idx_d[p]   = enc[p][TLBNUM_WIDTH-1:0];
        s_pg_d[p]    = '0;
        if (enc[p][TLBNUM_WIDTH]) begin
          s_pg_d[p] = s_odd[p]
                    ? ent_q[enc[p][TLBNUM_WIDTH-1:0]].pg1
                    : ent_q[enc[p][TLBNUM_WIDTH-1:0]].pg0;
        end
      end
    end
    p_done_d   = p_req;
    p_result_d = p_result_q;
    if (p_req) begin
      p_result_d = {~enc[2][TLBNUM_WIDTH],
                    enc[2][TLBNUM_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      present_q  <= '0;
      s_done_q   <= '0;
      s_found_q  <= '0;
      for (int p = 0; p < 2; p++) begin
        s_idx_q[p] <= '0;
        s_pg_q[p]  <= '0;
      end
      p_done_q   <= 1'b0;
      p_result_q <= {1'b1, {TLBNUM_WIDTH{1'b0}}};
    end else begin
      present_q  <= present_d;
      s_done_q   <= s_done_d;
      s_found_q  <= s_found_d;
      for (int p = 0; p < 2; p++) begin
        s_idx_q[p] <= s_idx_d[p];
        s_pg_q[p]  <= s_pg_d[p];
      end
      p_done_q   <= p_done_d;
      p_result_q <= p_result_d;
    end
  end

  assign s0_done  = s_done_q[0];
  assign s0_found = s_found_q[0];
  assign s0_index = s_idx_q[0];
  assign s0_pfn   = s_pg_q[0].pfn;
  assign s0_c     = s_pg_q[0].c;
  assign s0_d     = s_pg_q[0].d;
  assign s0_v     = s_pg_q[0].v;
  assign s1_done  = s_done_q[1];
  assign s1_found = s_found_q[1];
  assign s1_index = s_idx_q[1];
  assign s1_pfn   = s_pg_q[1].pfn;
  assign s1_c     = s_pg_q[1].c;
  assign s1_d     = s_pg_q[1].d;
  assign s1_v     = s_pg_q[1].v;
  assign p_done   = p_done_q;
  assign p_result = p_result_q;

  assign r_vpn2 = ent_q[r_index].vpn2;
  assign r_asid = ent_q[r_index].asid;
  assign r_g    = ent_q[r_index].g;
  assign r_pfn0 = ent_q[r_index].pg0.pfn;
  assign r_c0   = ent_q[r_index].pg0.c;
  assign r_d0   = ent_q[r_index].pg0.d;
  assign r_v0   = ent_q[r_index].pg0.v;
  assign r_pfn1 = ent_q[r_index].pg1.pfn;
  assign r_c1   = ent_q[r_index].pg1.c;
  assign r_d1   = ent_q[r_index].pg1.d;
  assign r_v1   = ent_q[r_index].pg1.v;

endmodule

// File: tb/tb_tlb.sv
// Directed self-checking bench for the TLB.
// Drives at posedge+1, samples at the following posedge+1.
module tb_tlb;

  logic        clk, reset;
  logic        s0_valid, s0_odd_page, s1_valid, s1_odd_page;
  logic [18:0] s0_vpn2, s1_vpn2, p_vpn2, w_vpn2, r_vpn2;
  logic [7:0]  s0_asid, s1_asid, p_asid, w_asid, r_asid;
  logic        s0_done, s0_found, s0_d, s0_v;
  logic        s1_done, s1_found, s1_d, s1_v;
  logic [3:0]  s0_index, s1_index, w_index, r_index;
  logic [19:0] s0_pfn, s1_pfn, w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  s0_c, s1_c, w_c0, w_c1, r_c0, r_c1;
  logic        p_req, p_done;
  logic [4:0]  p_result;
  logic        we, w_g, w_d0, w_v0, w_d1, w_v1, flush;
  logic        r_g, r_d0, r_v0, r_d1, r_v1;

  int n_cmp = 0;
  int n_bad = 0;

  tlb dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_vpn2(s0_vpn2),
    .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_done(s0_done), .s0_found(s0_found),
    .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_valid(s1_valid), .s1_vpn2(s1_vpn2),
    .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_done(s1_done), .s1_found(s1_found),
    .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid),
    .p_done(p_done), .p_result(p_result),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2),
    .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid),
    .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic clear_in();
    s0_valid = 0; s0_vpn2 = 0; s0_odd_page = 0; s0_asid = 0;
    s1_valid = 0; s1_vpn2 = 0; s1_odd_page = 0; s1_asid = 0;
    p_req = 0; p_vpn2 = 0; p_asid = 0;
    we = 0; w_index = 0; w_vpn2 = 0; w_asid = 0; w_g = 0;
    w_pfn0 = 0; w_c0 = 0; w_d0 = 0; w_v0 = 0;
    w_pfn1 = 0; w_c1 = 0; w_d1 = 0; w_v1 = 0;
    flush = 0;
  endtask

  task automatic set_wr(
    input logic [3:0] idx, input logic [18:0] vpn2,
    input logic [7:0] asid, input logic g,
    input logic [19:0] pfn0, input logic [2:0] c0,
    input logic d0, input logic v0,
    input logic [19:0] pfn1, input logic [2:0] c1,
    input logic d1, input logic v1
  );
    we = 1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  task automatic wr(
    input logic [3:0] idx, input logic [18:0] vpn2,
    input logic [7:0] asid, input logic g,
    input logic [19:0] pfn0, input logic [2:0] c0,
    input logic d0, input logic v0,
    input logic [19:0] pfn1, input logic [2:0] c1,
    input logic d1, input logic v1
  );
    @(posedge clk); #1;
    set_wr(idx, vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1);
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic s1_search(
    input logic [18:0] vpn2, input logic [7:0] asid,
    input logic odd
  );
    @(posedge clk); #1;
    s1_valid = 1; s1_vpn2 = vpn2; s1_asid = asid; s1_odd_page = odd;
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid);
    @(posedge clk); #1;
    p_req = 1; p_vpn2 = vpn2; p_asid = asid;
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (s0_done !== 1'b0) begin n_bad++; $display("FAIL rst_s0_done got=%0h exp=0", s0_done); end
    n_cmp++; if (s1_found !== 1'b0) begin n_bad++; $display("FAIL rst_s1_found got=%0h exp=0", s1_found); end
    n_cmp++; if (p_done !== 1'b0) begin n_bad++; $display("FAIL rst_p_done got=%0h exp=0", p_done); end
    n_cmp++; if (p_result !== 5'h10) begin n_bad++; $display("FAIL rst_p_result got=%0h exp=10", p_result); end
    n_cmp++; if (s1_pfn !== 20'h0) begin n_bad++; $display("FAIL rst_s1_pfn got=%0h exp=0", s1_pfn); end
    n_cmp++; if (s0_index !== 4'h0) begin n_bad++; $display("FAIL rst_s0_index got=%0h exp=0", s0_index); end
  endtask

  task automatic test_first_search();
    @(negedge clk);
    reset = 1;
    s0_valid = 1; s0_vpn2 = 19'h00001; s0_asid = 0;
    @(posedge clk); #1;
    clear_in();
    n_cmp++; if (s0_done !== 1'b1) begin n_bad++; $display("FAIL first_s0_done got=%0h exp=1", s0_done); end
    n_cmp++; if (s0_found !== 1'b0) begin n_bad++; $display("FAIL first_s0_found got=%0h exp=0", s0_found); end
    n_cmp++; if (p_done !== 1'b0) begin n_bad++; $display("FAIL first_p_done got=%0h exp=0", p_done); end
    n_cmp++; if (p_result !== 5'h10) begin n_bad++; $display("FAIL first_p_result got=%0h exp=10", p_result); end
    n_cmp++; if (s1_done !== 1'b0) begin n_bad++; $display("FAIL first_s1_done got=%0h exp=0", s1_done); end
    @(posedge clk); #1;
    n_cmp++; if (s0_done !== 1'b0) begin n_bad++; $display("FAIL first_s0_done_drop got=%0h exp=0", s0_done); end
  endtask

  task automatic test_search_odd_even();
    wr(4'd3, 19'h12345, 8'h05, 1'b0,
       20'h11111, 3'd2, 1'b0, 1'b1,
       20'hABCDE, 3'd3, 1'b1, 1'b1);
    r_index = 4'd3;
    s1_search(19'h12345, 8'h05, 1'b1);
    n_cmp++; if (s1_done !== 1'b1) begin n_bad++; $display("FAIL odd_done got=%0h exp=1", s1_done); end
    n_cmp++; if (s1_found !== 1'b1) begin n_bad++; $display("FAIL odd_found got=%0h exp=1", s1_found); end
    n_cmp++; if (s1_index !== 4'd3) begin n_bad++; $display("FAIL odd_index got=%0h exp=3", s1_index); end
    n_cmp++; if (s1_pfn !== 20'hABCDE) begin n_bad++; $display("FAIL odd_pfn got=%0h exp=abcde", s1_pfn); end
    n_cmp++; if ({s1_c, s1_d, s1_v} !== 5'b011_1_1) begin n_bad++; $display("FAIL odd_cdv got=%0h exp=f", {s1_c, s1_d, s1_v}); end
    n_cmp++; if (r_vpn2 !== 19'h12345) begin n_bad++; $display("FAIL rd_vpn2 got=%0h exp=12345", r_vpn2); end
    n_cmp++; if (r_pfn1 !== 20'hABCDE) begin n_bad++; $display("FAIL rd_pfn1 got=%0h exp=abcde", r_pfn1); end
    n_cmp++; if ({r_c0, r_d0, r_v0} !== 5'b010_0_1) begin n_bad++; $display("FAIL rd_cdv0 got=%0h exp=9", {r_c0, r_d0, r_v0}); end
    @(posedge clk); #1;
    n_cmp++; if (s1_done !== 1'b0) begin n_bad++; $display("FAIL hold_done got=%0h exp=0", s1_done); end
    n_cmp++; if (s1_pfn !== 20'hABCDE) begin n_bad++; $display("FAIL hold_pfn got=%0h exp=abcde", s1_pfn); end
    s1_search(19'h12345, 8'h05, 1'b0);
    n_cmp++; if (s1_pfn !== 20'h11111) begin n_bad++; $display("FAIL even_pfn got=%0h exp=11111", s1_pfn); end
    n_cmp++; if ({s1_c, s1_d, s1_v} !== 5'b010_0_1) begin n_bad++; $display("FAIL even_cdv got=%0h exp=9", {s1_c, s1_d, s1_v}); end
    s1_search(19'h12345, 8'h06, 1'b1);
    n_cmp++; if (s1_found !== 1'b0) begin n_bad++; $display("FAIL asid_miss_found got=%0h exp=0", s1_found); end
    n_cmp++; if (s1_index !== 4'd0) begin n_bad++; $display("FAIL asid_miss_index got=%0h exp=0", s1_index); end
    n_cmp++; if ({s1_pfn, s1_c, s1_d, s1_v} !== 25'h0) begin n_bad++; $display("FAIL asid_miss_payload got=%0h exp=0", {s1_pfn, s1_c, s1_d, s1_v}); end
  endtask

  task automatic test_priority_concurrent();
    wr(4'd7, 19'h2AAAA, 8'h03, 1'b1,
       20'h77777, 3'd1, 1'b0, 1'b1,
       20'h77770, 3'd1, 1'b0, 1'b1);
    wr(4'd2, 19'h2AAAA, 8'h09, 1'b0,
       20'h22222, 3'd4, 1'b1, 1'b1,
       20'h22220, 3'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    s0_valid = 1; s0_vpn2 = 19'h2AAAA; s0_asid = 8'h09; s0_odd_page = 0;
    s1_valid = 1; s1_vpn2 = 19'h12345; s1_asid = 8'h05; s1_odd_page = 1;
    p_req = 1; p_vpn2 = 19'h2AAAA; p_asid = 8'h09;
    @(posedge clk); #1;
    clear_in();
    n_cmp++; if (p_done !== 1'b1) begin n_bad++; $display("FAIL conc_p_done got=%0h exp=1", p_done); end
    n_cmp++; if (p_result !== 5'h02) begin n_bad++; $display("FAIL prio_asid9 got=%0h exp=02", p_result); end
    n_cmp++; if (s0_index !== 4'd2) begin n_bad++; $display("FAIL conc_s0_index got=%0h exp=2", s0_index); end
    n_cmp++; if (s0_pfn !== 20'h22222) begin n_bad++; $display("FAIL conc_s0_pfn got=%0h exp=22222", s0_pfn); end
    n_cmp++; if (s1_index !== 4'd3) begin n_bad++; $display("FAIL conc_s1_index got=%0h exp=3", s1_index); end
    n_cmp++; if (s1_pfn !== 20'hABCDE) begin n_bad++; $display("FAIL conc_s1_pfn got=%0h exp=abcde", s1_pfn); end
    probe(19'h2AAAA, 8'h01);
    n_cmp++; if (p_result !== 5'h07) begin n_bad++; $display("FAIL prio_global got=%0h exp=07", p_result); end
    @(posedge clk); #1;
    n_cmp++; if (p_done !== 1'b0) begin n_bad++; $display("FAIL p_done_drop got=%0h exp=0", p_done); end
  endtask

  task automatic test_write_collision();
    @(posedge clk); #1;
    set_wr(4'd4, 19'h0BEEF, 8'h20, 1'b0,
           20'h44444, 3'd0, 1'b0, 1'b1,
           20'h0, 3'd0, 1'b0, 1'b0);
    s0_valid = 1; s0_vpn2 = 19'h0BEEF; s0_asid = 8'h20; s0_odd_page = 0;
    @(posedge clk); #1;
    we = 0;
    n_cmp++; if (s0_found !== 1'b0) begin n_bad++; $display("FAIL coll_old_found got=%0h exp=0", s0_found); end
    @(posedge clk); #1;
    clear_in();
    n_cmp++; if (s0_found !== 1'b1) begin n_bad++; $display("FAIL coll_new_found got=%0h exp=1", s0_found); end
    n_cmp++; if (s0_index !== 4'd4) begin n_bad++; $display("FAIL coll_new_index got=%0h exp=4", s0_index); end
    n_cmp++; if (s0_pfn !== 20'h44444) begin n_bad++; $display("FAIL coll_new_pfn got=%0h exp=44444", s0_pfn); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    flush = 1;
    set_wr(4'd1, 19'h15555, 8'h01, 1'b0,
           20'h0F0F0, 3'd5, 1'b1, 1'b1,
           20'h0, 3'd0, 1'b0, 1'b0);
    s0_valid = 1; s0_vpn2 = 19'h12345; s0_asid = 8'h05; s0_odd_page = 1;
    p_req = 1; p_vpn2 = 19'h2AAAA; p_asid = 8'h01;
    @(posedge clk); #1;
    clear_in();
    n_cmp++; if (s0_index !== 4'd3) begin n_bad++; $display("FAIL flush_old_s0_index got=%0h exp=3", s0_index); end
    n_cmp++; if (p_result !== 5'h07) begin n_bad++; $display("FAIL flush_old_probe got=%0h exp=07", p_result); end
    probe(19'h15555, 8'h01);
    n_cmp++; if (p_result !== 5'h10) begin n_bad++; $display("FAIL flush_wr_probe got=%0h exp=10", p_result); end
    r_index = 4'd1;
    #1;
    n_cmp++; if (r_vpn2 !== 19'h15555) begin n_bad++; $display("FAIL flush_rd_vpn2 got=%0h exp=15555", r_vpn2); end
    n_cmp++; if (r_pfn0 !== 20'h0F0F0) begin n_bad++; $display("FAIL flush_rd_pfn0 got=%0h exp=f0f0", r_pfn0); end
    n_cmp++; if (r_c0 !== 3'd5) begin n_bad++; $display("FAIL flush_rd_c0 got=%0h exp=5", r_c0); end
    probe(19'h12345, 8'h05);
    n_cmp++; if (p_result !== 5'h10) begin n_bad++; $display("FAIL flush_old_gone got=%0h exp=10", p_result); end
  endtask

  task automatic test_reset_inflight();
    wr(4'd5, 19'h00055, 8'h00, 1'b1,
       20'h55555, 3'd1, 1'b1, 1'b1,
       20'h55550, 3'd1, 1'b1, 1'b1);
    @(posedge clk); #1;
    s0_valid = 1; s0_vpn2 = 19'h00055;
    s1_valid = 1; s1_vpn2 = 19'h00055;
    p_req = 1; p_vpn2 = 19'h00055;
    #3;
    reset = 0;
    #1;
    clear_in();
    n_cmp++; if (p_result !== 5'h10) begin n_bad++; $display("FAIL inflight_rst_p_result got=%0h exp=10", p_result); end
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_cmp++; if ({s0_done, s1_done, p_done} !== 3'b000) begin n_bad++; $display("FAIL inflight_done got=%0h exp=0", {s0_done, s1_done, p_done}); end
    end
    n_cmp++; if ({s0_found, s1_found} !== 2'b00) begin n_bad++; $display("FAIL inflight_found got=%0h exp=0", {s0_found, s1_found}); end
    n_cmp++; if ({s0_pfn, s1_index} !== 24'h0) begin n_bad++; $display("FAIL inflight_payload got=%0h exp=0", {s0_pfn, s1_index}); end
    n_cmp++; if (p_result !== 5'h10) begin n_bad++; $display("FAIL inflight_p_result got=%0h exp=10", p_result); end
    probe(19'h00055, 8'h00);
    n_cmp++; if (p_result !== 5'h10) begin n_bad++; $display("FAIL inflight_present_cleared got=%0h exp=10", p_result); end
  endtask

  initial begin
    reset = 0;
    r_index = 0;
    clear_in();
    test_reset();
    test_first_search();
    test_search_odd_even();
    test_priority_concurrent();
    test_write_collision();
    test_flush();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tlb.md
TLB -- requirements
Module: tlb

Interface
REQ-001 SHALL provide parameter TLBNUM, default 16, number of entries; legal values 2..64, power of two.
REQ-002 SHALL provide parameter TLBNUM_WIDTH, default $clog2(TLBNUM), width of the entry index.
REQ-003 SHALL provide clk  in  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL provide reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL provide s{0,1}_valid/s{0,1}_vpn2/s{0,1}_odd_page/s{0,1}_asid  in  1/19/1/8  search port 0 (fetch) and search port 1 (data).
REQ-006 SHALL provide s{0,1}_done/s{0,1}_found/s{0,1}_index/s{0,1}_pfn/s{0,1}_c/s{0,1}_d/s{0,1}_v  out  1/1/TLBNUM_WIDTH/20/3/1/1  registered search results.
REQ-007 SHALL provide p_req/p_vpn2/p_asid  in  1/19/8  probe request (TLBP).
REQ-008 SHALL provide p_done/p_result  out  1/TLBNUM_WIDTH+1  probe result; MSB is set when no entry matches, the low bits are the matching index.
REQ-009 SHALL provide we/w_index/w_vpn2/w_asid/w_g/w_pfn0/w_c0/w_d0/w_v0/w_pfn1/w_c1/w_d1/w_v1  in  1/TLBNUM_WIDTH/19/8/1/20/3/1/1/20/3/1/1  write port.
REQ-010 SHALL provide r_index  in  TLBNUM_WIDTH, and r_vpn2/r_asid/r_g/r_pfn0/r_c0/r_d0/r_v0/r_pfn1/r_c1/r_d1/r_v1  out  same widths as the write port; this is a combinational read port.
REQ-011 SHALL provide flush  in  1  synchronous invalidate of all entries.

Function
REQ-012 SHALL hold TLBNUM entries, each with a present bit plus vpn2, asid, g, and for each of pages 0 and 1: pfn, c, d, v.
REQ-013 An entry SHALL match when present=1, vpn2 is equal, and (g=1 or asid is equal).
REQ-014 When more than one entry matches, the lowest index SHALL win.
REQ-015 A search with s_valid=1 in cycle N SHALL present its result in cycle N+1, with s_done=1 for exactly that one cycle.
REQ-016 Search outputs SHALL hold their values until the next request; s_done SHALL be 0 in any cycle not following a request.
REQ-017 The pfn/c/d/v fields returned SHALL come from page 1 when odd_page=1 and from page 0 otherwise.
REQ-018 On a miss, found SHALL be 0 and index, pfn, c, d, v SHALL be 0.
REQ-019 A probe with p_req=1 in cycle N SHALL set p_done=1 in cycle N+1, with p_result = {~hit, hit_index}; on a miss the index bits SHALL be 0.
REQ-020 The two search ports and the probe port SHALL operate independently and concurrently, with no stall.
REQ-021 A write with we=1 in cycle N SHALL update entry w_index at the cycle-N edge and set its present bit.
REQ-022 A search or probe issued in the same cycle as a write SHALL see the old contents.
REQ-023 The read port SHALL reflect a write from the following cycle onward.
REQ-024 flush=1 SHALL clear every present bit at the edge.
REQ-025 When flush and we are asserted in the same cycle, flush SHALL take precedence and the written entry SHALL end up not present.
REQ-026 A search or probe issued alongside a flush SHALL see the pre-flush contents.
REQ-027 Stored g SHALL be w_g exactly as written; the TLB SHALL NOT AND the EntryLo G bits (the writer does that).
REQ-028 Every index SHALL be used modulo TLBNUM; no out-of-range access is possible.

Reset
REQ-029 While reset=0: all present bits, s*_done, s*_found, and p_done SHALL be 0; s*_index/pfn/c/d/v SHALL be 0; p_result SHALL be {1'b1, 0}.
REQ-030 Entry payload fields SHALL NOT be reset.
REQ-031 A request in flight when reset is asserted SHALL be discarded, with no done pulse after reset is released.
REQ-032 The first request SHALL be accepted in the first cycle after reset is released.

Structure
REQ-033 TLBNUM, entry field widths, and the probe-result miss-bit position SHALL live in the shared package tlb_pkg, which cp0 also uses.
REQ-034 Per-entry comparison SHALL be one sub-module, tlb_match (entry fields + vpn2 + asid -> hit), instantiated TLBNUM times per port, with a lowest-index priority encoder in the tlb module.
REQ-035 All outputs of the search and probe ports SHALL be registered; only the read port is combinational.

Verification
REQ-036 Reset then search s0 with vpn2=0x00001 -> cycle+1: s0_done=1, s0_found=0, p_result not touched; p_done=0.
REQ-037 Write idx 3 (vpn2=0x12345, asid=0x5, g=0, pfn1=0xABCDE, v1=1, d1=1, c1=3), then search s1 with vpn2=0x12345, asid=0x5, odd=1 -> found=1, index=3, pfn=0xABCDE, c=3, d=1, v=1; repeat with asid=0x6 -> found=0.
REQ-038 Same vpn2 written at idx 7 with g=1 and at idx 2 with asid=0x9; probe with asid=0x9 -> p_result=0x02; probe with asid=0x1 -> p_result=0x07.
REQ-039 Write idx 4 and search the same vpn2 in the same cycle -> found=0; repeating the search next cycle -> found=1, index=4.
REQ-040 flush and write idx 1 together -> probe of that vpn2 returns p_result=0x10 (miss); r_index=1 returns the new payload.
REQ-041 Issue s0, s1, and p_req in the same cycle, then assert reset mid-cycle before the edge -> no done pulses after release; all outputs at reset values.
